// File: rtl/crc8_pkg.sv
// Shared types and constants for the serial CRC-8 accumulator.
package crc8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } crc8_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         CNT_W     = 16;

endpackage

// File: rtl/crc8_step.sv
// One-bit CRC-8 step, MSB-first: feedback bit selects whether the
// generator polynomial is XORed into the shifted register.
module crc8_step #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc,
  input  logic       i,
  output logic [7:0] crc_next
);

  logic fb;

  // feedback from the outgoing MSB and the incoming data bit
  always_comb begin
    fb       = crc[7] ^ i;
    crc_next = {crc[6:0], 1'b0} ^ ({8{fb}} & POLY);
  end

endmodule

// File: rtl/crc8_acc.sv
// Serial CRC-8 accumulator with valid/ready bit input and a one-cycle
// completion pulse.
// Optional feature macro: CRC8_ACC_CHECK_EN adds exp input / err output
// comparing the final CRC against an expected value.
//
// state | meaning
// IDLE  | waiting for a sof bit; non-sof bits are accepted and dropped
// SHIFT | frame in progress, one bit folded per accepted beat
// HOLD  | single-cycle completion bubble, q/cnt final, done high
module crc8_acc
  import crc8_pkg::*;
(
  input  logic             ck,
  input  logic             nrst,
  input  logic             i,
  input  logic             vld,
  input  logic             sof,
  input  logic             eof,
  output logic             rdy,
  output logic [7:0]       q,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
`ifdef CRC8_ACC_CHECK_EN
  ,
  input  logic [7:0]       exp,
  output logic             err
`endif
);

  crc8_state_t state;
  logic        accept;
  logic        frame_bit;
  logic [7:0]  crc_base;
  logic [7:0]  crc_next;

  // handshake flags decode straight from the state register
  always_comb begin
    rdy       = (state != HOLD);
    busy      = (state == SHIFT);
    done      = (state == HOLD);
    accept    = vld & rdy;
    // a bit joins a frame if it starts one or arrives mid-frame
    frame_bit = accept & (sof | (state == SHIFT));
    crc_base  = sof ? CRC8_INIT : q;
  end

  crc8_step #(.POLY(CRC8_POLY)) u_step (
    .crc      (crc_base),
    .i        (i),
    .crc_next (crc_next)
  );

  // frame sequencing, CRC register and saturating bit counter
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      q     <= 8'h00;
      cnt   <= '0;
    end else begin
      case (state)
        HOLD: state <= IDLE;
        default: begin
          if (frame_bit) begin
            q <= crc_next;
            if (sof)
              cnt <= CNT_W'(1);
            else if (cnt != '1)
              cnt <= cnt + CNT_W'(1);
            state <= eof ? HOLD : SHIFT;
          end
        end
      endcase
    end
  end

`ifdef CRC8_ACC_CHECK_EN
  // compare at the eof beat so err lines up with done; cleared by a new sof
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      err <= 1'b0;
    end else if (frame_bit) begin
      if (eof)
        err <= (crc_next != exp);
      else if (sof)
        err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_crc8_acc.sv
// Self-checking bench for crc8_acc: reference model plus scoreboard of
// expected frame results popped on each done pulse.
module tb_crc8_acc;

  logic        ck;
  logic        nrst;
  logic        i;
  logic        vld;
  logic        sof;
  logic        eof;
  logic        rdy;
  logic [7:0]  q;
  logic [15:0] cnt;
  logic        busy;
  logic        done;
  logic [7:0]  exp_v;
  logic        err;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  crc8_acc dut (
    .ck   (ck),
    .nrst (nrst),
    .i    (i),
    .vld  (vld),
    .sof  (sof),
    .eof  (eof),
    .rdy  (rdy),
    .q    (q),
    .cnt  (cnt),
    .busy (busy),
    .done (done)
`ifdef CRC8_ACC_CHECK_EN
    ,
    .exp  (exp_v),
    .err  (err)
`endif
  );

`ifndef CRC8_ACC_CHECK_EN
  assign err = 1'b0;
`endif

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] r, input logic b);
    logic [7:0] t;
    t = r << 1;
    if (r[7] ^ b) t = t ^ 8'h07;
    return t;
  endfunction

  // reference model: 0 idle, 1 shift, 2 hold
  int          m_st;
  logic [7:0]  m_q;
  logic [15:0] m_cnt;
  logic        m_err;
  logic        m_acc;
  logic [24:0] sb[$];

  always @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      m_st = 0; m_q = 8'h00; m_cnt = 16'h0; m_err = 1'b0; m_acc = 1'b0;
    end else begin
      m_acc = 1'b0;
      if (m_st == 2) begin
        m_st = 0;
      end else if (vld) begin
        m_acc = 1'b1;
        if (sof || m_st == 1) begin
          m_q = ref_step(sof ? 8'h00 : m_q, i);
          if (sof) m_cnt = 16'd1;
          else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (sof) m_err = 1'b0;
          if (eof) begin
`ifdef CRC8_ACC_CHECK_EN
            m_err = (m_q != exp_v);
`endif
            m_st = 2;
            sb.push_back({m_err, m_cnt, m_q});
          end else begin
            m_st = 1;
          end
        end
      end
    end
  end

  // per-cycle comparison against the model, scoreboard pop on done
  always @(negedge ck) begin
    logic [24:0] e;
    chk("q", {24'h0, q}, {24'h0, m_q});
    chk("cnt", {16'h0, cnt}, {16'h0, m_cnt});
    chk("busy", {31'h0, busy}, {31'h0, (m_st == 1)});
    chk("rdy", {31'h0, rdy}, {31'h0, (m_st != 2)});
    chk("done", {31'h0, done}, {31'h0, (m_st == 2)});
`ifdef CRC8_ACC_CHECK_EN
    chk("err", {31'h0, err}, {31'h0, m_err});
`endif
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("done_unexp", {31'h0, done}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("sb_q", {24'h0, q}, {24'h0, e[7:0]});
        chk("sb_cnt", {16'h0, cnt}, {16'h0, e[23:8]});
`ifdef CRC8_ACC_CHECK_EN
        chk("sb_err", {31'h0, err}, {31'h0, e[24]});
`endif
      end
    end
  end

  task automatic send(input logic b, input logic s, input logic e, input bit gap);
    bit ok;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        vld = 1'b0;
        @(negedge ck);
      end
    end
    vld = 1'b1; i = b; sof = s; eof = e;
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(posedge ck);
      #1;
      if (m_acc) ok = 1'b1;
      @(negedge ck);
    end
    chk("accept_timeout", {31'h0, ok}, 32'h1);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit first, input bit last, input bit gap);
    for (int k = 7; k >= 0; k--)
      send(v[k], first && (k == 7), last && (k == 0), gap);
  endtask

  task automatic idle(input int n);
    vld = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (n) @(negedge ck);
  endtask

  logic [7:0] msg [9];
  int d0;

  initial begin
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    nrst = 1'b0; vld = 1'b0; i = 1'b0; sof = 1'b0; eof = 1'b0; exp_v = 8'h00;
    repeat (2) @(negedge ck);
    chk("rst_q", {24'h0, q}, 32'h0);
    chk("rst_cnt", {16'h0, cnt}, 32'h0);
    chk("rst_rdy", {31'h0, rdy}, 32'h1);
    nrst = 1'b1;
    idle(2);

    // 0x31 continuous
    d0 = n_done;
    send_byte(8'h31, 1, 1, 0);
    chk("t31_q", {24'h0, q}, 32'h97);
    chk("t31_cnt", {16'h0, cnt}, 32'd8);
    chk("t31_rdy", {31'h0, rdy}, 32'h0);
    idle(2);
    chk("t31_rdy_after", {31'h0, rdy}, 32'h1);
    chk("t31_ndone", n_done - d0, 32'd1);

    // "123456789" twice, back to back, matching then mismatching exp
    exp_v = 8'hF4;
    for (int n = 0; n < 9; n++) send_byte(msg[n], n == 0, n == 8, 0);
    chk("chk_q", {24'h0, q}, 32'hF4);
    chk("chk_cnt", {16'h0, cnt}, 32'd72);
`ifdef CRC8_ACC_CHECK_EN
    chk("chk_err0", {31'h0, err}, 32'h0);
`endif
    exp_v = 8'hF5;
    for (int n = 0; n < 9; n++) send_byte(msg[n], n == 0, n == 8, 0);
    chk("chk2_q", {24'h0, q}, 32'hF4);
    chk("chk2_done", {31'h0, done}, 32'h1);
`ifdef CRC8_ACC_CHECK_EN
    chk("chk_err1", {31'h0, err}, 32'h1);
`endif
    idle(2);

    // single-bit frames
    d0 = n_done;
    send(1'b1, 1, 1, 0);
    chk("one_q", {24'h0, q}, 32'h07);
    chk("one_cnt", {16'h0, cnt}, 32'd1);
    idle(1);
    send(1'b0, 1, 1, 0);
    chk("zero_q", {24'h0, q}, 32'h00);
    idle(2);
    chk("single_ndone", n_done - d0, 32'd2);

    // stalls inside the frame
    send_byte(8'h31, 1, 1, 1);
    chk("gap_q", {24'h0, q}, 32'h97);
    idle(2);

    // bits without sof in idle are dropped
    send(1'b1, 0, 0, 0);
    send(1'b0, 0, 1, 0);
    send(1'b1, 0, 0, 0);
    chk("drop_q", {24'h0, q}, 32'h97);
    chk("drop_cnt", {16'h0, cnt}, 32'd8);
    chk("drop_busy", {31'h0, busy}, 32'h0);
    idle(2);

    // restart after 5 bits
    d0 = n_done;
    send(1'b1, 1, 0, 0);
    send(1'b0, 0, 0, 0);
    send(1'b1, 0, 0, 0);
    send(1'b1, 0, 0, 0);
    send(1'b0, 0, 0, 0);
    send_byte(8'h31, 1, 1, 0);
    chk("rs_q", {24'h0, q}, 32'h97);
    chk("rs_cnt", {16'h0, cnt}, 32'd8);
    idle(3);
    chk("rs_ndone", n_done - d0, 32'd1);

    // async reset mid-frame
    d0 = n_done;
    send_byte(8'hA5, 1, 0, 0);
    idle(0);
    @(posedge ck);
    #2 nrst = 1'b0;
    #1;
    chk("ar_q", {24'h0, q}, 32'h0);
    chk("ar_cnt", {16'h0, cnt}, 32'h0);
    chk("ar_busy", {31'h0, busy}, 32'h0);
    chk("ar_rdy", {31'h0, rdy}, 32'h1);
    chk("ar_done", {31'h0, done}, 32'h0);
    repeat (2) @(negedge ck);
    nrst = 1'b1;
    idle(4);
    chk("ar_ndone", n_done - d0, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
